// File: rtl/mdr_mem_unit.sv
// mdr_mem_unit: memory-side datapath stage.
// Holds MAR and MDR, sources BusMuxInMDR, and runs a req/ack handshake to a
// word-addressed memory so reads and writes complete without sequencer help.
// busy/done/err report transaction progress back to the control sequencer.

module mdr_mem_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] mdr_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Wait counter only ever holds 0 .. TIMEOUT-1 before the timeout fires.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    WR_REQ,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  mar_q, mar_d;
  logic [DATA_W-1:0]  mdr_q_r, mdr_d;
  logic               req_d, we_d, busy_d, done_d, err_d;
  logic               timeout_hit;

  assign mdr_q     = mdr_q_r;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q_r;

  // Timeout fires on the last permitted waiting cycle; TIMEOUT of 0 waits forever.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic; the handshake outputs are computed
  // one cycle early here so they come straight out of flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q_r;
    req_d   = 1'b0;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mar_in) mar_d = bus_in[ADDR_W-1:0];
        if (mdr_in) mdr_d = bus_in;
        if (read && write) begin
          err_d = 1'b1;
        end else if (read) begin
          state_d = RD_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          busy_d  = 1'b1;
        end else if (write) begin
          state_d = WR_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      RD_REQ, WR_REQ: begin
        if (mem_ack) begin
          if (state_q == RD_REQ) mdr_d = mem_rdata;
          state_d = DONE;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          if (TIMEOUT != 0) cnt_d = cnt_q + CNT_W'(1);
          req_d  = 1'b1;
          we_d   = (state_q == WR_REQ);
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, registers and registered outputs; reset aborts any transaction at once.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q_r <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q_r <= mdr_d;
      mem_req <= req_d;
      mem_we  <= we_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_mdr_mem_unit.sv
// tb_mdr_mem_unit: directed plus randomized transactions against
// mdr_mem_unit, with expected values from a transaction-level model.

module tb_mdr_mem_unit;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [31:0] bus_in = '0;
  logic        mar_in = 1'b0, mdr_in = 1'b0, read = 1'b0, write = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mdr_q, mem_wdata;
  logic [8:0]  mem_addr;
  logic        mem_req, mem_we, busy, done, err;

  logic        mar_in0 = 1'b0, mdr_in0 = 1'b0, read0 = 1'b0, write0 = 1'b0;
  logic        mem_ack0 = 1'b0;
  logic [31:0] mdr_q0, mem_wdata0;
  logic [8:0]  mem_addr0;
  logic        mem_req0, mem_we0, busy0, done0, err0;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] mdl_mdr = '0;
  logic [8:0]  mdl_mar = '0;

  mdr_mem_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(TO)) dut (
    .clock(clock), .clear_n(clear_n), .bus_in(bus_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .read(read), .write(write),
    .mdr_q(mdr_q), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err)
  );

  mdr_mem_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .bus_in(bus_in),
    .mar_in(mar_in0), .mdr_in(mdr_in0), .read(read0), .write(write0),
    .mdr_q(mdr_q0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_ack(mem_ack0),
    .mem_rdata(mem_rdata), .busy(busy0), .done(done0), .err(err0)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic m,
                               input logic d, input logic r, input logic w);
    bus_in = b;
    mar_in = m;
    mdr_in = d;
    read   = r;
    write  = w;
  endtask

  // One complete transaction; the model decides how long mem_req stays up
  // and whether it ends in done or err, purely from the wait count.
  task automatic runTransaction(input logic is_write, input logic [8:0] addr,
                                input logic [31:0] data, input int wait_cycles,
                                input logic mdr_with_read, input logic poke);
    int  req_cycles;
    bit  times_out;
    times_out  = (wait_cycles >= TO);
    req_cycles = times_out ? TO : wait_cycles + 1;

    if (is_write) begin
      applyStimulus(data, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      mdl_mdr = data;
      applyStimulus({23'b0, addr}, 1'b1, 1'b0, 1'b0, 1'b1);
    end else begin
      applyStimulus({23'b0, addr}, 1'b1, mdr_with_read, 1'b1, 1'b0);
      if (mdr_with_read) mdl_mdr = {23'b0, addr};
    end
    mdl_mar = addr;
    @(negedge clock);
    applyStimulus(32'h0000AAAA, poke, poke, 1'b0, 1'b0);

    for (int k = 0; k < req_cycles; k++) begin
      checkOutput("req_high", 32'(mem_req), 32'd1);
      checkOutput("busy_high", 32'(busy), 32'd1);
      checkOutput("mem_we", 32'(mem_we), 32'(is_write));
      checkOutput("mem_addr", 32'(mem_addr), 32'(mdl_mar));
      checkOutput("mdr_hold", mdr_q, mdl_mdr);
      if (is_write) checkOutput("mem_wdata", mem_wdata, mdl_mdr);
      if (!times_out && k == wait_cycles) begin
        mem_ack   = 1'b1;
        mem_rdata = is_write ? ~data : data;
      end
      @(negedge clock);
      mem_ack = 1'b0;
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    if (!times_out && !is_write) mdl_mdr = data;
    checkOutput("done_pulse", 32'(done), times_out ? 32'd0 : 32'd1);
    checkOutput("err_pulse", 32'(err), times_out ? 32'd1 : 32'd0);
    checkOutput("req_drop", 32'(mem_req), 32'd0);
    checkOutput("busy_drop", 32'(busy), 32'd0);
    checkOutput("mdr_after", mdr_q, mdl_mdr);
    if (!times_out) applyStimulus(32'h13572468, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("done_clear", 32'(done), 32'd0);
    checkOutput("err_clear", 32'(err), 32'd0);
    checkOutput("idle_req", 32'(mem_req), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_mdr", mdr_q, mdl_mdr);
    checkOutput("idle_mar", 32'(mem_addr), 32'(mdl_mar));
  endtask

  initial begin
    logic        rw;
    int          wc;
    logic [31:0] d32;

    // Reset held: everything at zero.
    repeat (2) @(negedge clock);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done_err", {30'b0, done, err}, 32'd0);
    clear_n = 1'b1;
    @(negedge clock);
    checkOutput("rel_mdr", mdr_q, 32'd0);
    checkOutput("rel_mar", 32'(mem_addr), 32'd0);
    checkOutput("rel_req", 32'(mem_req), 32'd0);
    checkOutput("rel_busy", 32'(busy), 32'd0);

    // Reset in the middle of a read drops mem_req at once; MDR not loaded.
    applyStimulus(32'h3, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_rdata = 32'hCAFEF00D;
    checkOutput("midrd_req", 32'(mem_req), 32'd1);
    #2 clear_n = 1'b0;
    #1;
    checkOutput("abort_req", 32'(mem_req), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_mdr", mdr_q, 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    mdl_mdr = '0;
    mdl_mar = '0;
    @(negedge clock);

    // Directed: zero-wait read, 3-wait write, timed-out read.
    runTransaction(1'b0, 9'h005, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    runTransaction(1'b1, 9'h1FF, 32'h12345678, 3, 1'b0, 1'b0);
    runTransaction(1'b0, 9'h0A3, 32'h55667788, 20, 1'b0, 1'b0);
    runTransaction(1'b0, 9'h021, 32'h0F0F0F0F, 2, 1'b0, 1'b1);

    // Read and write together: error pulse, no memory access.
    applyStimulus(32'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("conflict_err", 32'(err), 32'd1);
    checkOutput("conflict_req", 32'(mem_req), 32'd0);
    checkOutput("conflict_done", 32'(done), 32'd0);
    @(negedge clock);
    checkOutput("conflict_err_once", 32'(err), 32'd0);
    checkOutput("conflict_req2", 32'(mem_req), 32'd0);

    // Stray ack while idle changes nothing.
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clock);
    mem_ack = 1'b0;
    checkOutput("stray_busy", 32'(busy), 32'd0);
    checkOutput("stray_done", 32'(done), 32'd0);
    checkOutput("stray_mdr", mdr_q, mdl_mdr);

    // Randomized transactions.
    for (int i = 0; i < 16; i++) begin
      rw  = 1'($urandom_range(0, 1));
      d32 = $urandom;
      wc  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 18))
                                        : int'($urandom_range(0, 4));
      runTransaction(rw, 9'($urandom), d32, wc,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Timeout disabled: a 40-cycle wait completes without error.
    bus_in  = 32'h7;
    mar_in0 = 1'b1;
    read0   = 1'b1;
    @(negedge clock);
    mar_in0 = 1'b0;
    read0   = 1'b0;
    for (int k = 0; k < 41; k++) begin
      checkOutput("nto_req", 32'(mem_req0), 32'd1);
      checkOutput("nto_err", 32'(err0), 32'd0);
      if (k == 0) begin
        checkOutput("nto_addr", 32'(mem_addr0), 32'd7);
        checkOutput("nto_we", 32'(mem_we0), 32'd0);
        checkOutput("nto_busy", 32'(busy0), 32'd1);
      end
      if (k == 40) begin
        mem_ack0  = 1'b1;
        mem_rdata = 32'h0BADF00D;
      end
      @(negedge clock);
      mem_ack0 = 1'b0;
    end
    checkOutput("nto_done", 32'(done0), 32'd1);
    checkOutput("nto_err_end", 32'(err0), 32'd0);
    checkOutput("nto_mdr", mdr_q0, 32'h0BADF00D);
    checkOutput("nto_wdata", mem_wdata0, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
